// File: rtl/ysyx_22050078_mem_arb.sv
// Shares the single memory port between instruction fetch (IF) and load/store (LS), one transaction at a time.
// Define YSYX_22050078_ARB_RR_EN for round-robin arbitration; otherwise LS has fixed priority over IF.
module ysyx_22050078_mem_arb #(
   parameter int unsigned ADDR_W = 64,
   parameter int unsigned DATA_W = 64
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                if_req_valid,
   input  logic [ADDR_W-1:0]   if_addr,
   output logic                if_req_ready,
   output logic                if_resp_valid,
   output logic [DATA_W-1:0]   if_rdata,
   input  logic                ls_req_valid,
   input  logic [ADDR_W-1:0]   ls_addr,
   input  logic                ls_wen,
   input  logic [DATA_W-1:0]   ls_wdata,
   input  logic [DATA_W/8-1:0] ls_wmask,
   output logic                ls_req_ready,
   output logic                ls_resp_valid,
   output logic [DATA_W-1:0]   ls_rdata,
   output logic                mem_req_valid,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic                mem_wen,
   output logic [DATA_W-1:0]   mem_wdata,
   output logic [DATA_W/8-1:0] mem_wmask,
   input  logic                mem_req_ready,
   input  logic                mem_resp_valid,
   input  logic [DATA_W-1:0]   mem_rdata,
   output logic                busy
);

   localparam int unsigned MASK_W = DATA_W / 8;

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_e;
   typedef enum logic {OWN_IF, OWN_LS} owner_e;

   state_e              state_q, state_d;
   owner_e              owner_q, owner_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic                wen_q, wen_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [MASK_W-1:0]   wmask_q, wmask_d;
   logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
   logic [DATA_W-1:0]   ls_rdata_q, ls_rdata_d;
   logic                if_resp_q, if_resp_d;
   logic                ls_resp_q, ls_resp_d;
   logic                req_valid_q, req_valid_d;
   logic                busy_q, busy_d;
   logic                accept_c;
   logic                grant_ls_c;

   assign accept_c = (state_q == S_IDLE) && (if_req_valid || ls_req_valid);

`ifdef YSYX_22050078_ARB_RR_EN
   owner_e last_grant_q, last_grant_d;

   // On a tie, the requester not granted last time wins.
   assign grant_ls_c   = ls_req_valid && (!if_req_valid || (last_grant_q == OWN_IF));
   assign last_grant_d = accept_c ? (grant_ls_c ? OWN_LS : OWN_IF) : last_grant_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) last_grant_q <= OWN_LS;
      else        last_grant_q <= last_grant_d;
   end
`else
   assign grant_ls_c = ls_req_valid;
`endif

   // Next-state, latching and handshake decode.
   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      addr_d       = addr_q;
      wen_d        = wen_q;
      wdata_d      = wdata_q;
      wmask_d      = wmask_q;
      if_rdata_d   = if_rdata_q;
      ls_rdata_d   = ls_rdata_q;
      if_resp_d    = 1'b0;
      ls_resp_d    = 1'b0;
      req_valid_d  = req_valid_q;
      busy_d       = busy_q;
      if_req_ready = 1'b0;
      ls_req_ready = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (accept_c) begin
               // Ready is gated by reset so every output reads 0 while reset is held.
               if_req_ready = rst_n && !grant_ls_c;
               ls_req_ready = rst_n && grant_ls_c;
               owner_d      = grant_ls_c ? OWN_LS : OWN_IF;
               addr_d       = grant_ls_c ? ls_addr : if_addr;
               wen_d        = grant_ls_c && ls_wen;
               wdata_d      = grant_ls_c ? ls_wdata : '0;
               wmask_d      = grant_ls_c ? ls_wmask : '0;
               req_valid_d  = 1'b1;
               busy_d       = 1'b1;
               state_d      = S_REQ;
            end
         end
         S_REQ: begin
            if (mem_req_ready) begin
               req_valid_d = 1'b0;
               state_d     = S_WAIT;
            end
         end
         S_WAIT: begin
            if (mem_resp_valid) begin
               if (owner_q == OWN_IF) begin
                  if_rdata_d = mem_rdata;
                  if_resp_d  = 1'b1;
               end else begin
                  ls_rdata_d = wen_q ? '0 : mem_rdata;
                  ls_resp_d  = 1'b1;
               end
               state_d = S_RESP;
            end
         end
         S_RESP: begin
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         owner_q     <= OWN_IF;
         addr_q      <= '0;
         wen_q       <= 1'b0;
         wdata_q     <= '0;
         wmask_q     <= '0;
         if_rdata_q  <= '0;
         ls_rdata_q  <= '0;
         if_resp_q   <= 1'b0;
         ls_resp_q   <= 1'b0;
         req_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         addr_q      <= addr_d;
         wen_q       <= wen_d;
         wdata_q     <= wdata_d;
         wmask_q     <= wmask_d;
         if_rdata_q  <= if_rdata_d;
         ls_rdata_q  <= ls_rdata_d;
         if_resp_q   <= if_resp_d;
         ls_resp_q   <= ls_resp_d;
         req_valid_q <= req_valid_d;
         busy_q      <= busy_d;
      end
   end

   assign if_resp_valid = if_resp_q;
   assign ls_resp_valid = ls_resp_q;
   assign if_rdata      = if_rdata_q;
   assign ls_rdata      = ls_rdata_q;
   assign mem_req_valid = req_valid_q;
   assign mem_addr      = addr_q;
   assign mem_wen       = wen_q;
   assign mem_wdata     = wdata_q;
   assign mem_wmask     = wmask_q;
   assign busy          = busy_q;

endmodule

// File: tb/tb_ysyx_22050078_mem_arb.sv
// Bench for ysyx_22050078_mem_arb: directed latency/reset scenarios plus a randomized run against a transaction-level model.
// Build with YSYX_22050078_ARB_RR_EN defined to check the round-robin variant.
module tb_ysyx_22050078_mem_arb;

   localparam int unsigned AW = 64;
   localparam int unsigned DW = 64;
   localparam int unsigned MW = DW / 8;
`ifdef YSYX_22050078_ARB_RR_EN
   localparam bit RR_MODE = 1'b1;
`else
   localparam bit RR_MODE = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic          if_req_valid = 1'b0;
   logic [AW-1:0] if_addr = '0;
   logic          if_req_ready, if_resp_valid;
   logic [DW-1:0] if_rdata;
   logic          ls_req_valid = 1'b0;
   logic [AW-1:0] ls_addr = '0;
   logic          ls_wen = 1'b0;
   logic [DW-1:0] ls_wdata = '0;
   logic [MW-1:0] ls_wmask = '0;
   logic          ls_req_ready, ls_resp_valid;
   logic [DW-1:0] ls_rdata;
   logic          mem_req_valid, mem_wen, busy;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [MW-1:0] mem_wmask;
   logic          mem_req_ready = 1'b0;
   logic          mem_resp_valid = 1'b0;
   logic [DW-1:0] mem_rdata = '0;

   int n_vec = 0;
   int n_err = 0;

   // memory responder state
   int            rphase = 0;
   int            rcnt = 0;
   int            req_wait = 0;
   int            resp_wait = 0;
   bit            rand_wait = 1'b0;
   bit            spurious = 1'b0;
   logic          hs_new = 1'b0, resp_new = 1'b0, hs_unstable = 1'b0;
   logic [AW-1:0] hs_addr = '0, snap_addr = '0;
   logic [DW-1:0] hs_wdata = '0, snap_wdata = '0, resp_data = '0;
   logic [MW-1:0] hs_wmask = '0, snap_wmask = '0;
   logic          hs_wen = 1'b0, snap_wen = 1'b0;

   always #5 clk = ~clk;

   ysyx_22050078_mem_arb #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .clk(clk), .rst_n(rst_n),
      .if_req_valid(if_req_valid), .if_addr(if_addr), .if_req_ready(if_req_ready),
      .if_resp_valid(if_resp_valid), .if_rdata(if_rdata),
      .ls_req_valid(ls_req_valid), .ls_addr(ls_addr), .ls_wen(ls_wen), .ls_wdata(ls_wdata),
      .ls_wmask(ls_wmask), .ls_req_ready(ls_req_ready), .ls_resp_valid(ls_resp_valid),
      .ls_rdata(ls_rdata),
      .mem_req_valid(mem_req_valid), .mem_addr(mem_addr), .mem_wen(mem_wen),
      .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .mem_req_ready(mem_req_ready),
      .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata), .busy(busy)
   );

   function automatic logic [63:0] mem_fn(input logic [63:0] a);
      if (a == 64'h8000_0000) return 64'h0000_0000_0000_0413;
      return {a[31:0] ^ 32'h5A5A_1234, a[63:32] + 32'h1};
   endfunction

   // Advance one clock, then act as the memory for the coming edge.
   task automatic tick();
      @(posedge clk);
      #1;
      hs_new         = 1'b0;
      resp_new       = 1'b0;
      mem_req_ready  = 1'b0;
      mem_resp_valid = 1'b0;
      mem_rdata      = {$urandom, $urandom};
      if (!rst_n) begin
         rphase = 0;
         return;
      end
      if (rphase == 0 && mem_req_valid) begin
         rphase      = 1;
         rcnt        = rand_wait ? int'($urandom_range(0, 3)) : req_wait;
         snap_addr   = mem_addr;
         snap_wen    = mem_wen;
         snap_wdata  = mem_wdata;
         snap_wmask  = mem_wmask;
         hs_unstable = 1'b0;
      end
      if (rphase == 1) begin
         if ({mem_addr, mem_wen, mem_wdata, mem_wmask} !== {snap_addr, snap_wen, snap_wdata, snap_wmask})
            hs_unstable = 1'b1;
         if (rcnt == 0) begin
            mem_req_ready = 1'b1;
            hs_new   = 1'b1;
            hs_addr  = mem_addr;
            hs_wen   = mem_wen;
            hs_wdata = mem_wdata;
            hs_wmask = mem_wmask;
            rphase   = 2;
            rcnt     = rand_wait ? int'($urandom_range(0, 3)) : resp_wait;
         end else begin
            rcnt = rcnt - 1;
            if (spurious) mem_resp_valid = ($urandom_range(0, 3) == 0);
         end
      end else if (rphase == 2) begin
         if (rcnt == 0) begin
            mem_resp_valid = 1'b1;
            mem_rdata      = mem_fn(hs_addr);
            resp_data      = mem_rdata;
            resp_new       = 1'b1;
            rphase         = 0;
         end else begin
            rcnt = rcnt - 1;
         end
      end else if (spurious && !busy) begin
         mem_resp_valid = ($urandom_range(0, 3) == 0);
      end
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      if_req_valid = 1'b0;
      ls_req_valid = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_reset();
      rst_n = 1'b1;
      #2;
      rst_n = 1'b0;
      if_req_valid = 1'b1;
      ls_req_valid = 1'b1;
      #1;
      n_vec++;
      if ({if_req_ready, ls_req_ready, if_resp_valid, ls_resp_valid, mem_req_valid, busy} !== 6'b0) begin
         n_err++;
         $display("FAIL reset_ctrl: got %b want 000000",
                  {if_req_ready, ls_req_ready, if_resp_valid, ls_resp_valid, mem_req_valid, busy});
      end
      n_vec++;
      if ({if_rdata, ls_rdata, mem_addr, mem_wdata, mem_wmask, mem_wen} !== '0) begin
         n_err++;
         $display("FAIL reset_data: if_rdata=%h ls_rdata=%h mem_addr=%h mem_wdata=%h mem_wmask=%h mem_wen=%b want all 0",
                  if_rdata, ls_rdata, mem_addr, mem_wdata, mem_wmask, mem_wen);
      end
      apply_reset();
   endtask

   task automatic test_lone_fetch();
      bit ls_seen = 1'b0;
      rand_wait = 1'b0; spurious = 1'b0; req_wait = 0; resp_wait = 0;
      if_addr = 64'h8000_0000;
      if_req_valid = 1'b1;
      #1;
      n_vec++;
      if (if_req_ready !== 1'b1 || ls_req_ready !== 1'b0) begin
         n_err++;
         $display("FAIL fetch_c0_ready: if_req_ready=%b ls_req_ready=%b want 1 0", if_req_ready, ls_req_ready);
      end
      tick();
      if_req_valid = 1'b0;
      if_addr = {$urandom, $urandom};
      n_vec++;
      if (mem_req_valid !== 1'b1 || mem_addr !== 64'h8000_0000 || mem_wen !== 1'b0 || mem_wmask !== 8'h00) begin
         n_err++;
         $display("FAIL fetch_c1_mem: valid=%b addr=%h wen=%b wmask=%h want 1 80000000 0 00",
                  mem_req_valid, mem_addr, mem_wen, mem_wmask);
      end
      for (int c = 2; c <= 4; c++) begin
         tick();
         ls_seen |= ls_resp_valid;
         n_vec++;
         if (if_resp_valid !== (c == 3) || (c == 3 && if_rdata !== 64'h413)) begin
            n_err++;
            $display("FAIL fetch_c%0d_resp: if_resp_valid=%b if_rdata=%h want %b 0000000000000413",
                     c, if_resp_valid, if_rdata, (c == 3));
         end
      end
      n_vec++;
      if (ls_seen !== 1'b0 || busy !== 1'b0) begin
         n_err++;
         $display("FAIL fetch_ls_quiet: ls_resp_seen=%b busy=%b want 0 0", ls_seen, busy);
      end
   endtask

   task automatic test_store();
      ls_wen = 1'b1; ls_addr = 64'h8000_1000; ls_wdata = 64'hDEAD_BEEF; ls_wmask = 8'h0F;
      ls_req_valid = 1'b1;
      #1;
      n_vec++;
      if (ls_req_ready !== 1'b1 || if_req_ready !== 1'b0) begin
         n_err++;
         $display("FAIL store_c0_ready: ls_req_ready=%b if_req_ready=%b want 1 0", ls_req_ready, if_req_ready);
      end
      tick();
      ls_req_valid = 1'b0;
      ls_wdata = {$urandom, $urandom};
      n_vec++;
      if (mem_req_valid !== 1'b1 || mem_wen !== 1'b1 || mem_wmask !== 8'h0F ||
          mem_wdata !== 64'hDEAD_BEEF || mem_addr !== 64'h8000_1000) begin
         n_err++;
         $display("FAIL store_c1_mem: valid=%b wen=%b wmask=%h wdata=%h addr=%h want 1 1 0f deadbeef 80001000",
                  mem_req_valid, mem_wen, mem_wmask, mem_wdata, mem_addr);
      end
      tick();
      tick();
      n_vec++;
      if (ls_resp_valid !== 1'b1 || ls_rdata !== 64'h0 || if_resp_valid !== 1'b0 || if_rdata !== 64'h413) begin
         n_err++;
         $display("FAIL store_c3_resp: ls_resp=%b ls_rdata=%h if_resp=%b if_rdata=%h want 1 0 0 413",
                  ls_resp_valid, ls_rdata, if_resp_valid, if_rdata);
      end
      tick();
      ls_wen = 1'b0;
   endtask

   task automatic test_wait_states();
      rand_wait = 1'b0; req_wait = 2; resp_wait = 3;
      if_addr = 64'h8000_2000;
      if_req_valid = 1'b1;
      #1;
      tick();
      if_req_valid = 1'b0;
      for (int c = 1; c <= 9; c++) begin
         n_vec++;
         if (busy !== (c <= 8) || mem_req_valid !== (c <= 3) || if_resp_valid !== (c == 8)) begin
            n_err++;
            $display("FAIL wait_c%0d: busy=%b mem_req_valid=%b if_resp_valid=%b want %b %b %b",
                     c, busy, mem_req_valid, if_resp_valid, (c <= 8), (c <= 3), (c == 8));
         end
         tick();
      end
      n_vec++;
      if (hs_unstable !== 1'b0 || hs_addr !== 64'h8000_2000 || if_rdata !== mem_fn(64'h8000_2000)) begin
         n_err++;
         $display("FAIL wait_stable: unstable=%b hs_addr=%h if_rdata=%h want 0 80002000 %h",
                  hs_unstable, hs_addr, if_rdata, mem_fn(64'h8000_2000));
      end
      req_wait = 0; resp_wait = 0;
   endtask

   task automatic test_reset_in_wait();
      bit stale = 1'b0;
      resp_wait = 5;
      if_addr = 64'h8000_3000;
      if_req_valid = 1'b1;
      #1;
      tick();
      if_req_valid = 1'b0;
      tick();
      rst_n = 1'b0;
      if_req_valid = 1'b1;
      #1;
      n_vec++;
      if ({if_req_ready, ls_req_ready, if_resp_valid, ls_resp_valid, mem_req_valid, busy,
           if_rdata, ls_rdata, mem_addr, mem_wdata, mem_wmask, mem_wen} !== '0) begin
         n_err++;
         $display("FAIL rst_wait_outputs: busy=%b mem_req_valid=%b if_req_ready=%b mem_addr=%h if_rdata=%h want all 0",
                  busy, mem_req_valid, if_req_ready, mem_addr, if_rdata);
      end
      if_req_valid = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      resp_wait = 0;
      for (int c = 0; c < 3; c++) begin
         tick();
         stale |= if_resp_valid | ls_resp_valid | busy;
      end
      if_addr = 64'h8000_0000;
      if_req_valid = 1'b1;
      #1;
      tick();
      if_req_valid = 1'b0;
      tick();
      stale |= if_resp_valid | ls_resp_valid;
      tick();
      n_vec++;
      if (stale !== 1'b0 || if_resp_valid !== 1'b1 || if_rdata !== 64'h413) begin
         n_err++;
         $display("FAIL rst_wait_refetch: stale=%b if_resp_valid=%b if_rdata=%h want 0 1 413",
                  stale, if_resp_valid, if_rdata);
      end
      tick();
   endtask

   task automatic test_back_to_back();
      logic exp_ls, got_ls, last_ls;
      int gap;
      apply_reset();
      last_ls = 1'b1;
      rand_wait = 1'b0; spurious = 1'b0; req_wait = 0; resp_wait = 0;
      ls_wen = 1'b0;
      if_addr = {$urandom, $urandom};
      ls_addr = {$urandom, $urandom};
      if_req_valid = 1'b1;
      ls_req_valid = 1'b1;
      #1;
      gap = 0;
      for (int t = 0; t < 3; t++) begin
         while (!(if_req_ready || ls_req_ready) && gap < 20) begin
            tick();
            gap++;
         end
         exp_ls = RR_MODE ? !last_ls : 1'b1;
         got_ls = ls_req_ready;
         n_vec++;
         if (got_ls !== exp_ls || if_req_ready === ls_req_ready || (t > 0 && gap != 4)) begin
            n_err++;
            $display("FAIL b2b_grant%0d: ls_ready=%b if_ready=%b gap=%0d want ls_ready=%b gap=4",
                     t, ls_req_ready, if_req_ready, gap, exp_ls);
         end
         last_ls = exp_ls;
         tick();
         gap = 1;
         if (got_ls) ls_addr = {$urandom, $urandom};
         else        if_addr = {$urandom, $urandom};
      end
      if_req_valid = 1'b0;
      ls_req_valid = 1'b0;
      for (int i = 0; i < 10 && busy; i++) tick();
      n_vec++;
      if (busy !== 1'b0) begin
         n_err++;
         $display("FAIL b2b_drain: busy=%b want 0", busy);
      end
   endtask

   task automatic test_random();
      logic m_busy, m_release, m_resp_due, m_last_ls, m_own_ls, m_exp_wen;
      logic win_ls, any_v, if_acc, ls_acc;
      logic [63:0] m_exp_addr, m_exp_wdata, m_if_rd, m_ls_rd, m_resp_d;
      logic [7:0]  m_exp_wmask;
      apply_reset();
      m_busy = 0; m_release = 0; m_resp_due = 0; m_last_ls = 1; m_own_ls = 0; m_exp_wen = 0;
      m_exp_addr = '0; m_exp_wdata = '0; m_exp_wmask = '0; m_if_rd = '0; m_ls_rd = '0; m_resp_d = '0;
      if_acc = 0; ls_acc = 0;
      rand_wait = 1'b1; spurious = 1'b1;
      for (int c = 0; c < 600; c++) begin
         if (m_release) begin
            m_busy = 0;
            m_release = 0;
         end
         n_vec++;
         if (busy !== m_busy || if_resp_valid !== (m_resp_due && !m_own_ls) ||
             ls_resp_valid !== (m_resp_due && m_own_ls)) begin
            n_err++;
            $display("FAIL rnd_status@%0d: busy=%b if_resp=%b ls_resp=%b want %b %b %b", c, busy,
                     if_resp_valid, ls_resp_valid, m_busy, m_resp_due && !m_own_ls, m_resp_due && m_own_ls);
         end
         if (m_resp_due) begin
            if (m_own_ls) m_ls_rd = m_resp_d;
            else          m_if_rd = m_resp_d;
            m_resp_due = 0;
            m_release = 1;
         end
         n_vec++;
         if (if_rdata !== m_if_rd || ls_rdata !== m_ls_rd) begin
            n_err++;
            $display("FAIL rnd_rdata@%0d: if_rdata=%h ls_rdata=%h want %h %h", c, if_rdata, ls_rdata, m_if_rd, m_ls_rd);
         end
         if (hs_new) begin
            n_vec++;
            if (hs_unstable || hs_addr !== m_exp_addr || hs_wen !== m_exp_wen || hs_wmask !== m_exp_wmask ||
                (m_exp_wen && hs_wdata !== m_exp_wdata)) begin
               n_err++;
               $display("FAIL rnd_memreq@%0d: unstable=%b addr=%h wen=%b wmask=%h wdata=%h want 0 %h %b %h %h", c,
                        hs_unstable, hs_addr, hs_wen, hs_wmask, hs_wdata, m_exp_addr, m_exp_wen, m_exp_wmask, m_exp_wdata);
            end
         end
         if (resp_new) begin
            m_resp_due = 1;
            m_resp_d = m_exp_wen ? 64'h0 : resp_data;
         end
         if (!if_req_valid || if_acc) begin
            if_req_valid = 1'($urandom_range(0, 1));
            if_addr = {$urandom, $urandom};
         end
         if (!ls_req_valid || ls_acc) begin
            ls_req_valid = 1'($urandom_range(0, 1));
            ls_addr = {$urandom, $urandom};
            ls_wen = 1'($urandom_range(0, 1));
            ls_wdata = {$urandom, $urandom};
            ls_wmask = 8'($urandom);
         end
         if_acc = 0;
         ls_acc = 0;
         #1;
         any_v = if_req_valid || ls_req_valid;
         if (if_req_valid && ls_req_valid) win_ls = RR_MODE ? !m_last_ls : 1'b1;
         else                              win_ls = ls_req_valid;
         n_vec++;
         if (if_req_ready !== (!m_busy && any_v && !win_ls) || ls_req_ready !== (!m_busy && any_v && win_ls)) begin
            n_err++;
            $display("FAIL rnd_ready@%0d: if_ready=%b ls_ready=%b want %b %b", c, if_req_ready, ls_req_ready,
                     !m_busy && any_v && !win_ls, !m_busy && any_v && win_ls);
         end
         if (!m_busy && any_v) begin
            m_busy = 1;
            m_own_ls = win_ls;
            m_last_ls = win_ls;
            m_exp_addr = win_ls ? ls_addr : if_addr;
            m_exp_wen = win_ls && ls_wen;
            m_exp_wmask = win_ls ? ls_wmask : 8'h00;
            m_exp_wdata = ls_wdata;
            if_acc = !win_ls;
            ls_acc = win_ls;
         end
         tick();
      end
      if_req_valid = 1'b0;
      ls_req_valid = 1'b0;
      for (int i = 0; i < 20 && busy; i++) tick();
      n_vec++;
      if (busy !== 1'b0) begin
         n_err++;
         $display("FAIL rnd_drain: busy=%b want 0", busy);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, busy=%b", busy);
      $fatal(1);
   end

   initial begin
      test_reset();
      test_lone_fetch();
      test_store();
      test_wait_states();
      test_reset_in_wait();
      test_back_to_back();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
